// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and Gray-code helpers shared by the write-side and
// read-side controllers of the dual-clock FIFO.
//   FIFO_ADDR_WIDTH : memory address width (depth = 2**FIFO_ADDR_WIDTH)
//   FIFO_PTR_WIDTH  : pointer width, MSB is the wrap bit
//   bin2gray/gray2bin operate on 32-bit values so callers of any pointer
//   width up to 32 can cast in and out.
package fifo_pkg;
  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs decode correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_sync.sv
// gray_sync: multi-flop synchronizer for a Gray-coded bus crossing into the
// clk domain. Shared by the write and read sides of the FIFO.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input bus (must change by at most one bit at a time)
//   q     : last stage, STAGES clk edges behind d
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Stage 0 samples d; stage STAGES-1 is the output.
  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer/full controller of the dual-clock FIFO.
// Everything runs on WR_CLK.
//   WR_CLK      : write clock
//   WR_RST      : asynchronous active-low reset
//   WR_INC      : write request this cycle
//   GRAY_RD_PTR : Gray read pointer from the read domain (asynchronous)
//   WR_ADDR     : memory write address (low bits of binary write pointer)
//   MEM_WR_EN   : memory write strobe, WR_INC & ~WR_FULL
//   GRAY_WR_PTR : registered Gray write pointer for the read domain
//   WR_FULL     : FIFO full as seen from the write domain
//   WR_OVERFLOW : sticky write-while-full flag, only with FIFO_WR_OVERFLOW_EN
// Optional feature macro: FIFO_WR_OVERFLOW_EN.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int PTR_WIDTH   = ADDR_WIDTH + 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  WR_CLK,
  input  logic                  WR_RST,
  input  logic                  WR_INC,
  input  logic [PTR_WIDTH-1:0]  GRAY_RD_PTR,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic                  MEM_WR_EN,
  output logic [PTR_WIDTH-1:0]  GRAY_WR_PTR,
  output logic                  WR_FULL
`ifdef FIFO_WR_OVERFLOW_EN
  ,
  output logic                  WR_OVERFLOW
`endif
);
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr_next;
  logic [PTR_WIDTH-1:0] gray_next;
  logic [PTR_WIDTH-1:0] rd_gray_sync;

  gray_sync #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk   (WR_CLK),
    .rst_n (WR_RST),
    .d     (GRAY_RD_PTR),
    .q     (rd_gray_sync)
  );

  // Full when the write pointer is exactly one lap ahead of the synchronized
  // read pointer: in Gray code that is the top two bits inverted. Both
  // operands are flops, so a stale read pointer only ever holds full longer.
  assign WR_FULL   = (GRAY_WR_PTR == {~rd_gray_sync[PTR_WIDTH-1 -: 2],
                                      rd_gray_sync[PTR_WIDTH-3:0]});
  assign MEM_WR_EN = WR_INC & ~WR_FULL;

  assign wr_ptr_next = wr_ptr + PTR_WIDTH'(MEM_WR_EN);
  assign gray_next   = PTR_WIDTH'(bin2gray(32'(wr_ptr_next)));
  assign WR_ADDR     = wr_ptr[ADDR_WIDTH-1:0];

  // Gray pointer is registered from the next binary value so the read
  // domain only ever sees single-bit transitions.
  always_ff @(posedge WR_CLK or negedge WR_RST) begin
    if (!WR_RST) begin
      wr_ptr      <= '0;
      GRAY_WR_PTR <= '0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      GRAY_WR_PTR <= gray_next;
    end
  end

`ifdef FIFO_WR_OVERFLOW_EN
  always_ff @(posedge WR_CLK or negedge WR_RST) begin
    if (!WR_RST)                WR_OVERFLOW <= 1'b0;
    else if (WR_INC && WR_FULL) WR_OVERFLOW <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl. The reference model tracks the number of
// accepted writes and the read count the DUT has had time to see; full means
// the two differ by exactly the FIFO depth (modulo the pointer range).
module tb_fifo_wr_ctrl;
  localparam int AW    = 3;
  localparam int PW    = 4;
  localparam int SS    = 2;
  localparam int DEPTH = 1 << AW;

  logic          WR_CLK;
  logic          WR_RST;
  logic          WR_INC;
  logic [PW-1:0] GRAY_RD_PTR;
  logic [AW-1:0] WR_ADDR;
  logic          MEM_WR_EN;
  logic [PW-1:0] GRAY_WR_PTR;
  logic          WR_FULL;
`ifdef FIFO_WR_OVERFLOW_EN
  logic          WR_OVERFLOW;
`endif

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .PTR_WIDTH(PW), .SYNC_STAGES(SS)) dut (
    .WR_CLK      (WR_CLK),
    .WR_RST      (WR_RST),
    .WR_INC      (WR_INC),
    .GRAY_RD_PTR (GRAY_RD_PTR),
    .WR_ADDR     (WR_ADDR),
    .MEM_WR_EN   (MEM_WR_EN),
    .GRAY_WR_PTR (GRAY_WR_PTR),
    .WR_FULL     (WR_FULL)
`ifdef FIFO_WR_OVERFLOW_EN
    ,
    .WR_OVERFLOW (WR_OVERFLOW)
`endif
  );

  initial begin
    WR_CLK = 1'b0;
    forever #5 WR_CLK = ~WR_CLK;
  end

  typedef struct {
    int addr;
    int gray;
    int full;
    int wen;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // ---------------- reference model ----------------
  int  wr_cnt;        // accepted writes since reset
  int  rd_drv;        // read count currently driven on GRAY_RD_PTR
  int  rd_hist[$];    // read counts in flight through the synchronizer
  bit  ovf_m;
  bit  in_reset;
  bit  inc_prev;
  bit  full_prev;
  bit  wen_prev;
  int  rd_prev;

  function automatic int to_gray(input int v);
    int m;
    m = v % (2 * DEPTH);
    return m ^ (m >> 1);
  endfunction

  task automatic model_clear();
    wr_cnt = 0;
    ovf_m  = 1'b0;
    rd_hist.delete();
    for (int i = 0; i < SS; i++) rd_hist.push_back(0);
    inc_prev  = 1'b0;
    full_prev = 1'b0;
    wen_prev  = 1'b0;
    rd_prev   = 0;
  endtask

  // Effects of the previous cycle's inputs at this rising edge.
  task automatic model_edge();
    if (!in_reset) begin
      if (wen_prev) wr_cnt++;
      if (inc_prev && full_prev) ovf_m = 1'b1;
      rd_hist.push_back(rd_prev);
      void'(rd_hist.pop_front());
    end
  endtask

  task automatic push_exp(input bit inc);
    exp_t e;
    bit   full;
    full   = (((wr_cnt - rd_hist[0]) % (2 * DEPTH) + 2 * DEPTH) % (2 * DEPTH)) == DEPTH;
    e.addr = wr_cnt % DEPTH;
    e.gray = to_gray(wr_cnt);
    e.full = int'(full);
    e.wen  = int'(inc && !full);
    e.ovf  = int'(ovf_m);
    exp_q.push_back(e);
    inc_prev  = inc;
    full_prev = full;
    wen_prev  = inc && !full;
    rd_prev   = rd_drv;
  endtask

  // One clock cycle of stimulus; releases reset first if it was held.
  task automatic cycle(input bit inc, input int rd);
    @(posedge WR_CLK);
    model_edge();
    #1;
    if (in_reset) begin
      WR_RST   = 1'b1;
      in_reset = 1'b0;
    end
    rd_drv      = rd;
    WR_INC      = inc;
    GRAY_RD_PTR = PW'(to_gray(rd));
    push_exp(inc);
  endtask

  // Reset asserted between clock edges; the same cycle checks the outputs.
  task automatic mid_reset();
    @(posedge WR_CLK);
    model_edge();
    #1;
    WR_INC      = 1'b0;
    rd_drv      = 0;
    GRAY_RD_PTR = '0;
    #1;
    WR_RST   = 1'b0;
    in_reset = 1'b1;
    model_clear();
    push_exp(1'b0);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge WR_CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wr_addr",     int'(WR_ADDR),     e.addr);
      chk("gray_wr_ptr", int'(GRAY_WR_PTR), e.gray);
      chk("wr_full",     int'(WR_FULL),     e.full);
      chk("mem_wr_en",   int'(MEM_WR_EN),   e.wen);
`ifdef FIFO_WR_OVERFLOW_EN
      chk("wr_overflow", int'(WR_OVERFLOW), e.ovf);
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rd;
    int wait_cnt;
    WR_RST      = 1'b0;
    WR_INC      = 1'b0;
    GRAY_RD_PTR = '0;
    rd_drv      = 0;
    in_reset    = 1'b1;
    model_clear();

    // Reset state and idle.
    mid_reset();
    repeat (3) cycle(1'b0, 0);

    // Fill: eight writes, then writes while full.
    repeat (8) cycle(1'b1, 0);
    repeat (3) cycle(1'b1, 0);

    // One read: full drops SYNC_STAGES edges later, then one write.
    rd = 1;
    repeat (SS + 1) cycle(1'b0, rd);
    cycle(1'b1, rd);
    cycle(1'b0, rd);

    // Interleaved writes and reads across the pointer wrap.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, rd);
      if (rd < wr_cnt) rd++;
      cycle(1'b0, rd);
    end
    repeat (SS + 2) begin
      if (rd < wr_cnt) rd++;
      cycle(1'b0, rd);
    end

    // Reset between edges after five writes.
    mid_reset();
    rd = 0;
    cycle(1'b0, 0);
    repeat (5) cycle(1'b1, 0);
    mid_reset();
    cycle(1'b1, 0);
    cycle(1'b1, 0);
    cycle(1'b0, 0);

    // Random traffic; reads lag writes and are sparser so full is reached.
    rd = 0;
    for (int i = 0; i < 400; i++) begin
      if (rd < wr_cnt && $urandom_range(0, 99) < 35) rd++;
      cycle(bit'($urandom_range(0, 1)), rd);
      if (i == 200) begin
        mid_reset();
        rd = 0;
      end
    end
    repeat (2) cycle(1'b0, rd);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge WR_CLK);
      wait_cnt++;
    end
    #1;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
